mem_port_arbiter: RTL and testbench

//   Shares the single-port synchronous program/data memory between two masters:
//   M0 (CPU side) and M1 (host loader / debug port).

---
 rtl/mem_port_arbiter_if.sv | 24 ++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - one master's request/response port into mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin, burst-lockable arbiter sharing one sync memory port between two masters
module mem_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.slave   m0,
  mem_port_arbiter_if.slave   m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_data_out,
  input  logic [DATA_W-1:0]   mem_data_in
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic              m0_gnt_r, m1_gnt_r;
  logic              m0_rvalid_r, m1_rvalid_r;
  logic              mem_we_r;
  logic              last;
  logic              last_valid;
  logic [CNT_W-1:0]  burst_cnt;
  logic              busy_owner;
  logic              busy_read;

  logic              any_req;
  logic              last_lock;
  logic              winner;
  logic              same_master;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [CNT_W-1:0]  cnt_next;

  // last_valid keeps the post-reset value of `last` from acting as a lock owner,
  // so the very first tie always goes to M0.
  always_comb begin
    any_req   = m0.req | m1.req;
    last_lock = last ? m1.lock : m0.lock;
    if (m0.req && m1.req) begin
      if (last_valid && last_lock && (burst_cnt < MAX_CNT))
        winner = last;
      else
        winner = ~last;
    end else begin
      winner = m1.req;
    end
    win_we      = winner ? m1.we    : m0.we;
    win_addr    = winner ? m1.addr  : m0.addr;
    win_wdata   = winner ? m1.wdata : m0.wdata;
    same_master = last_valid && (winner == last);
    if (!same_master)
      cnt_next = '0;
    else if (burst_cnt == MAX_CNT)
      cnt_next = burst_cnt;
    else
      cnt_next = burst_cnt + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      m0_gnt_r     <= 1'b0;
      m1_gnt_r     <= 1'b0;
      m0_rvalid_r  <= 1'b0;
      m1_rvalid_r  <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_address  <= '0;
      mem_data_out <= '0;
      last         <= 1'b1;
      last_valid   <= 1'b0;
      burst_cnt    <= '0;
      busy_owner   <= 1'b0;
      busy_read    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          m0_rvalid_r <= 1'b0;
          m1_rvalid_r <= 1'b0;
          if (any_req) begin
            mem_address  <= win_addr;
            mem_we_r     <= win_we;
            mem_data_out <= win_wdata;
            m0_gnt_r     <= ~winner;
            m1_gnt_r     <= winner;
            busy_owner   <= winner;
            busy_read    <= ~win_we;
            last         <= winner;
            last_valid   <= 1'b1;
            burst_cnt    <= cnt_next;
            state        <= BUSY;
          end else begin
            mem_we_r <= 1'b0;
          end
        end
        BUSY: begin
          m0_gnt_r    <= 1'b0;
          m1_gnt_r    <= 1'b0;
          mem_we_r    <= 1'b0;
          m0_rvalid_r <= busy_read & ~busy_owner;
          m1_rvalid_r <= busy_read & busy_owner;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gating with reset keeps a write from landing when reset hits mid-access.
  assign mem_we    = mem_we_r & ~reset;
  assign m0.gnt    = m0_gnt_r;
  assign m1.gnt    = m1_gnt_r;
  assign m0.rvalid = m0_rvalid_r;
  assign m1.rvalid = m1_rvalid_r;
  assign m0.rdata  = mem_data_in;
  assign m1.rdata  = mem_data_in;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a behavioural sync memory
module tb_mem_port_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_address;
  logic        mem_we;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = '0;
  logic [31:0] bd_data = '0;
  logic [31:0] mem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) m0_if ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) m1_if ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_BURST(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .m0           (m0_if),
    .m1           (m1_if),
    .mem_address  (mem_address),
    .mem_we       (mem_we),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in)
  );

  always #5 clock = ~clock;

  // Synchronous single-port memory; bd_* is a preload backdoor used only while idle.
  always @(posedge clock) begin
    if (bd_we)
      mem[bd_addr] <= bd_data;
    else if (mem_we)
      mem[mem_address] <= mem_data_out;
    mem_data_in <= mem[mem_address];
  end

  task automatic set_m(input bit m, input bit req, input bit we, input bit lock,
                       input logic [15:0] a, input logic [31:0] d);
    if (m) begin
      m1_if.req = req; m1_if.we = we; m1_if.lock = lock; m1_if.addr = a; m1_if.wdata = d;
    end else begin
      m0_if.req = req; m0_if.we = we; m0_if.lock = lock; m0_if.addr = a; m0_if.wdata = d;
    end
  endtask

  task automatic apply_reset();
    set_m(0, 0, 0, 0, '0, '0);
    set_m(1, 0, 0, 0, '0, '0);
    q0.delete();
    q1.delete();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clock);
    bd_we = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid, mem_we} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 00000",
                         {m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid, mem_we});
    end
    n_checks++;
    if (mem_address !== 16'h0 || mem_data_out !== 32'h0 || dut.burst_cnt !== 3'd0) begin
      n_fail++; $display("FAIL reset_data: addr=%h wdata=%h cnt=%0d required 0/0/0",
                         mem_address, mem_data_out, dut.burst_cnt);
    end
  endtask

  task automatic test_read_m0();
    apply_reset();
    preload(16'h0005, 32'hDEADBEEF);
    set_m(0, 1, 0, 0, 16'h0005, '0);
    q0.push_back(32'hDEADBEEF);
    @(negedge clock);
    n_checks++;
    if (m0_if.gnt !== 1'b1 || m1_if.gnt !== 1'b0 || mem_address !== 16'h0005 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL rd0_gnt: gnt0=%b gnt1=%b addr=%h we=%b required 1 0 0005 0",
                         m0_if.gnt, m1_if.gnt, mem_address, mem_we);
    end
    set_m(0, 0, 0, 0, '0, '0);
    @(negedge clock);
    n_checks++;
    if (m0_if.rvalid !== 1'b1 || m0_if.gnt !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL rd0_rvalid: rvalid=%b gnt=%b we=%b required 1 0 0",
                         m0_if.rvalid, m0_if.gnt, mem_we);
    end else begin
      n_checks++;
      if (m0_if.rdata !== q0.pop_front()) begin
        n_fail++; $display("FAIL rd0_data: got %h required DEADBEEF", m0_if.rdata);
      end
    end
    @(negedge clock);
    n_checks++;
    if (m0_if.rvalid !== 1'b0 || m1_if.rvalid !== 1'b0) begin
      n_fail++; $display("FAIL rd0_pulse: rvalid0=%b rvalid1=%b required 0 0", m0_if.rvalid, m1_if.rvalid);
    end
  endtask

  task automatic test_write_m1();
    apply_reset();
    set_m(1, 1, 1, 0, 16'h0010, 32'h12345678);
    @(negedge clock);
    n_checks++;
    if (m1_if.gnt !== 1'b1 || mem_we !== 1'b1 || mem_address !== 16'h0010 || mem_data_out !== 32'h12345678) begin
      n_fail++; $display("FAIL wr1_busy: gnt=%b we=%b addr=%h data=%h required 1 1 0010 12345678",
                         m1_if.gnt, mem_we, mem_address, mem_data_out);
    end
    set_m(1, 0, 0, 0, '0, '0);
    @(negedge clock);
    n_checks++;
    if (mem_we !== 1'b0 || m1_if.rvalid !== 1'b0 || m0_if.rvalid !== 1'b0) begin
      n_fail++; $display("FAIL wr1_after: we=%b rvalid1=%b rvalid0=%b required 0 0 0",
                         mem_we, m1_if.rvalid, m0_if.rvalid);
    end
    set_m(1, 1, 0, 0, 16'h0010, '0);
    q1.push_back(32'h12345678);
    @(negedge clock);
    set_m(1, 0, 0, 0, '0, '0);
    @(negedge clock);
    n_checks++;
    if (m1_if.rvalid !== 1'b1) begin
      n_fail++; $display("FAIL wr1_readback_valid: rvalid=%b required 1", m1_if.rvalid);
    end else begin
      n_checks++;
      if (m1_if.rdata !== q1.pop_front()) begin
        n_fail++; $display("FAIL wr1_readback: got %h required 12345678", m1_if.rdata);
      end
    end
  endtask

  // Both masters hold read requests; exp_seq gives the grant order, exp_cnt the burst count.
  task automatic run_contention(input string name, input bit m1_lock,
                                input int exp_seq [8], input int exp_cnt [8]);
    int g = 0;
    logic [31:0] e;
    apply_reset();
    preload(16'h0020, 32'hA0A00000);
    preload(16'h0021, 32'hA1A11111);
    set_m(0, 1, 0, 0, 16'h0020, '0);
    set_m(1, 1, 0, m1_lock, 16'h0021, '0);
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      n_checks++;
      if ((m0_if.gnt | m1_if.gnt) !== (c % 2 == 0) || (m0_if.gnt & m1_if.gnt) !== 1'b0 ||
          (m0_if.gnt & m0_if.rvalid) !== 1'b0 || (m1_if.gnt & m1_if.rvalid) !== 1'b0) begin
        n_fail++; $display("FAIL %s_cadence c=%0d: gnt0=%b gnt1=%b rv0=%b rv1=%b required one gnt on even c",
                           name, c, m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid);
      end
      if ((m0_if.gnt || m1_if.gnt) && g < 8) begin
        n_checks++;
        if (int'(m1_if.gnt) !== exp_seq[g] || int'(dut.burst_cnt) !== exp_cnt[g]) begin
          n_fail++; $display("FAIL %s_grant g=%0d: master=%0d cnt=%0d required %0d %0d",
                             name, g, m1_if.gnt, dut.burst_cnt, exp_seq[g], exp_cnt[g]);
        end
        if (m1_if.gnt) q1.push_back(32'hA1A11111); else q0.push_back(32'hA0A00000);
        g++;
      end
      if (m0_if.rvalid) begin
        n_checks++;
        e = (q0.size() > 0) ? q0.pop_front() : 32'hxxxxxxxx;
        if (m0_if.rdata !== e) begin
          n_fail++; $display("FAIL %s_rdata0: got %h required %h", name, m0_if.rdata, e);
        end
      end
      if (m1_if.rvalid) begin
        n_checks++;
        e = (q1.size() > 0) ? q1.pop_front() : 32'hxxxxxxxx;
        if (m1_if.rdata !== e) begin
          n_fail++; $display("FAIL %s_rdata1: got %h required %h", name, m1_if.rdata, e);
        end
      end
    end
    set_m(0, 0, 0, 0, '0, '0);
    set_m(1, 0, 0, 0, '0, '0);
    n_checks++;
    if (g != 8 || q0.size() != 0 || q1.size() != 0) begin
      n_fail++; $display("FAIL %s_total: grants=%0d pending=%0d/%0d required 8 0/0",
                         name, g, q0.size(), q1.size());
    end
  endtask

  task automatic test_alternate();
    run_contention("alt", 1'b0, '{0, 1, 0, 1, 0, 1, 0, 1}, '{0, 0, 0, 0, 0, 0, 0, 0});
  endtask

  task automatic test_lock();
    run_contention("lock", 1'b1, '{0, 1, 1, 1, 1, 1, 0, 1}, '{0, 0, 1, 2, 3, 4, 0, 0});
  endtask

  task automatic test_single();
    int g = 0;
    int ecnt;
    logic [31:0] e;
    apply_reset();
    for (int i = 0; i < 10; i++) preload(16'h0040 + 16'(i), 32'hC0DE0000 + 32'(i));
    set_m(0, 1, 0, 0, 16'h0040, '0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      n_checks++;
      if (m0_if.gnt !== (c % 2 == 0) || m1_if.gnt !== 1'b0) begin
        n_fail++; $display("FAIL single_gnt c=%0d: gnt0=%b gnt1=%b required %0d 0",
                           c, m0_if.gnt, m1_if.gnt, (c % 2 == 0));
      end
      if (m0_if.rvalid) begin
        n_checks++;
        e = (q0.size() > 0) ? q0.pop_front() : 32'hxxxxxxxx;
        if (m0_if.rdata !== e) begin
          n_fail++; $display("FAIL single_rdata c=%0d: got %h required %h", c, m0_if.rdata, e);
        end
      end
      if (m0_if.gnt) begin
        ecnt = (g > 4) ? 4 : g;
        n_checks++;
        if (int'(dut.burst_cnt) !== ecnt) begin
          n_fail++; $display("FAIL single_cnt g=%0d: got %0d required %0d", g, dut.burst_cnt, ecnt);
        end
        q0.push_back(32'hC0DE0000 + 32'(g));
        g++;
        if (g < 10) set_m(0, 1, 0, 0, 16'h0040 + 16'(g), '0);
        else        set_m(0, 0, 0, 0, '0, '0);
      end
    end
    n_checks++;
    if (g != 10 || q0.size() != 0) begin
      n_fail++; $display("FAIL single_total: grants=%0d pending=%0d required 10 0", g, q0.size());
    end
  endtask

  task automatic test_reset_busy();
    apply_reset();
    preload(16'h0030, 32'h55AA55AA);
    set_m(0, 1, 1, 0, 16'h0030, 32'hFFFF0000);
    @(negedge clock);
    n_checks++;
    if (m0_if.gnt !== 1'b1 || dut.mem_we_r !== 1'b1) begin
      n_fail++; $display("FAIL rstbusy_setup: gnt=%b we_r=%b required 1 1", m0_if.gnt, dut.mem_we_r);
    end
    reset = 1'b1;
    set_m(0, 0, 0, 0, '0, '0);
    #1;
    n_checks++;
    if (mem_we !== 1'b0) begin
      n_fail++; $display("FAIL rstbusy_we_gate: mem_we=%b required 0", mem_we);
    end
    @(negedge clock);
    reset = 1'b0;
    n_checks++;
    if ({m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid, mem_we} !== 5'b0 ||
        mem_address !== 16'h0 || mem_data_out !== 32'h0) begin
      n_fail++; $display("FAIL rstbusy_outputs: ctrl=%b addr=%h data=%h required 00000 0000 00000000",
                         {m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid, mem_we}, mem_address, mem_data_out);
    end
    @(negedge clock);
    n_checks++;
    if (m0_if.rvalid !== 1'b0 || mem[16'h0030] !== 32'h55AA55AA) begin
      n_fail++; $display("FAIL rstbusy_mem: rvalid=%b mem=%h required 0 55AA55AA", m0_if.rvalid, mem[16'h0030]);
    end
    set_m(0, 1, 0, 0, 16'h0030, '0);
    q0.push_back(32'h55AA55AA);
    @(negedge clock);
    set_m(0, 0, 0, 0, '0, '0);
    @(negedge clock);
    n_checks++;
    if (m0_if.rvalid !== 1'b1 || m0_if.rdata !== q0[0]) begin
      n_fail++; $display("FAIL rstbusy_readback: rvalid=%b data=%h required 1 55AA55AA", m0_if.rvalid, m0_if.rdata);
    end
    q0.delete();
  endtask

  initial begin
    test_reset();
    test_read_m0();
    test_write_m1();
    test_alternate();
    test_lock();
    test_single();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
